// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter for up to four masters.
// Fixed-length bursts and locked sequences hold the grant until they complete.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic [3:0] HBUSREQ,
  input  logic [3:0] HLOCK,
  input  logic [1:0] HTRANS,
  input  logic [2:0] HBURST,
  input  logic       HREADY,
  output logic [3:0] HGRANT,
  output logic [1:0] HMASTER,
  output logic       HMASTLOCK
);

  typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;
  typedef enum logic [1:0] {TR_IDLE, TR_BUSY, TR_NONSEQ, TR_SEQ} htrans_t;

  localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
  localparam logic [3:0] DEF_GRANT = 4'(1) << DEFAULT_MASTER;

  logic [3:0] r_grant;
  logic [1:0] r_master;
  logic       r_mastlock;
  logic [3:0] r_count;
  state_t     r_state;

  state_t     w_state_next;
  htrans_t    w_trans;
  logic [1:0] w_owner;
  logic       w_owner_lock;
  logic [3:0] w_next_count;
  logic       w_hold;
  logic [3:0] w_next_grant;
  logic [1:0] w_cand;
  logic       w_found;

  assign w_trans      = htrans_t'(HTRANS);
  assign w_owner_lock = HLOCK[w_owner];

  always_comb begin
    w_owner = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_grant[i]) w_owner = 2'(i);
    end
  end

  // Counter holds remaining SEQ beats of the current burst
  always_comb begin
    w_next_count = r_count;
    unique case (w_trans)
      TR_IDLE: w_next_count = '0;
      TR_BUSY: w_next_count = r_count;
      TR_NONSEQ: begin
        case (HBURST)
          3'b000, 3'b001: w_next_count = '0;
          3'b010, 3'b011: w_next_count = 4'd3;
          3'b100, 3'b101: w_next_count = 4'd7;
          default:        w_next_count = 4'd15;
        endcase
      end
      TR_SEQ: w_next_count = (r_count == '0) ? '0 : r_count - 4'd1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    if (HREADY) begin
      if (w_owner_lock)              w_state_next = LOCKED;
      else if (w_next_count != '0)   w_state_next = BURST;
      else                           w_state_next = ARB;
    end
    w_hold = (w_state_next != ARB) || (w_trans == TR_BUSY);
  end

  // Search starts after the owner so the owner is considered last
  always_comb begin
    w_found      = 1'b0;
    w_cand       = '0;
    w_next_grant = DEF_GRANT;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      w_cand = 2'((32'(w_owner) + i) % NUM_MASTERS);
      if (!w_found && HBUSREQ[w_cand]) begin
        w_found      = 1'b1;
        w_next_grant = 4'(1) << w_cand;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_grant    <= DEF_GRANT;
      r_master   <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_count    <= '0;
      r_state    <= ARB;
    end else if (HREADY) begin
      r_count    <= w_next_count;
      r_state    <= w_state_next;
      r_master   <= w_owner;
      r_mastlock <= w_owner_lock;
      if (!w_hold) r_grant <= w_next_grant;
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;

endmodule
